// File: rtl/arbiter_types.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | arbiter_types : shared FSM state and grant encodings for cache_arbiter        |
// | Revision 1.0                                                                  |
// +-----------------------------------------------------------------------------+
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cache_arbiter : round-robin arbiter sharing one cacheline adaptor between     |
// | the icache and dcache. Revision 1.0                                          |
// +-----------------------------------------------------------------------------+
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state;
  grant_t     last_grant;
  logic       i_active;
  logic       d_active;

  assign i_active = i_pmem_read;
  assign d_active = d_pmem_read | d_pmem_write;

  // last_grant only changes on entry to a SERVE state, so a tie favours whoever waited
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      case (state)
        IDLE: begin
          if (i_active && d_active) begin
            if (last_grant == GRANT_I) begin
              state      <= SERVE_D;
              last_grant <= GRANT_D;
            end else begin
              state      <= SERVE_I;
              last_grant <= GRANT_I;
            end
          end else if (d_active) begin
            state      <= SERVE_D;
            last_grant <= GRANT_D;
          end else if (i_active) begin
            state      <= SERVE_I;
            last_grant <= GRANT_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // Outside SERVE_I the dcache owns the address/data bus; only the strobes are gated
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = d_pmem_address;
    pmem_wdata   = d_pmem_wdata;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (state)
      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end
      SERVE_D: begin
        pmem_read   = d_pmem_read;
        pmem_write  = d_pmem_write;
        d_pmem_resp = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, cacheline data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, physical address width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_pmem_read, input, 1, icache line-read request.
REQ-006 The block SHALL have port i_pmem_address, input, ADDR_W, icache line address.
REQ-007 The block SHALL have port i_pmem_rdata, output, LINE_W, line data returned to the icache.
REQ-008 The block SHALL have port i_pmem_resp, output, 1, icache completion pulse.
REQ-009 The block SHALL have ports d_pmem_read and d_pmem_write, input, 1 each, dcache line-read and line-write requests.
REQ-010 The block SHALL have ports d_pmem_address (input, ADDR_W) and d_pmem_wdata (input, LINE_W), carrying the dcache address and writeback data.
REQ-011 The block SHALL have ports d_pmem_rdata (output, LINE_W) and d_pmem_resp (output, 1), carrying dcache read data and the dcache completion pulse.
REQ-012 The block SHALL have ports pmem_read, pmem_write (output, 1 each), pmem_address (output, ADDR_W) and pmem_wdata (output, LINE_W), driving the cacheline adaptor.
REQ-013 The block SHALL have ports pmem_rdata (input, LINE_W) and pmem_resp (input, 1), returned by the cacheline adaptor.

Function
REQ-014 The FSM SHALL have states IDLE, SERVE_I, SERVE_D and DONE.
REQ-015 In IDLE with exactly one requester active, the FSM SHALL go to that requester's SERVE state; dcache is active when d_pmem_read or d_pmem_write is high.
REQ-016 In IDLE with both requesters active, the FSM SHALL grant the requester not granted last (round-robin); the last_grant flag SHALL be updated on entry to a SERVE state.
REQ-017 In SERVE_I, the block SHALL drive pmem_read=i_pmem_read, pmem_write=0 and pmem_address=i_pmem_address; pmem_wdata is don't-care.
REQ-018 In SERVE_D, the block SHALL pass d_pmem_read, d_pmem_write, d_pmem_address and d_pmem_wdata through to the pmem outputs.
REQ-019 In IDLE and DONE, pmem_read and pmem_write SHALL be 0, and pmem_address/pmem_wdata SHALL hold the dcache inputs.
REQ-020 i_pmem_resp SHALL equal pmem_resp only in SERVE_I; d_pmem_resp SHALL equal pmem_resp only in SERVE_D; both SHALL be 0 otherwise.
REQ-021 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata in every state.
REQ-022 On pmem_resp in a SERVE state, the FSM SHALL go to DONE; DONE SHALL last exactly one cycle and then go to IDLE, so the requester can deassert.
REQ-023 Latency: a request sampled in IDLE at edge N SHALL assert a pmem strobe in cycle N+1; back-to-back service SHALL cost 2 idle-strobe cycles (DONE, IDLE).
REQ-024 A requester dropping its request during SERVE is a protocol violation; the FSM SHALL stay in SERVE until pmem_resp regardless.
REQ-025 d_pmem_read and d_pmem_write both high is illegal; the block SHALL pass both through unchanged (no masking).
REQ-026 A request arriving while the other requester is being served SHALL wait; it SHALL be granted in the IDLE cycle after DONE.

Reset
REQ-027 On rst high the FSM SHALL go to IDLE immediately (asynchronously), including mid-SERVE; strobes and resps SHALL go to 0 in the same cycle.
REQ-028 Reset SHALL set last_grant to icache, so the first simultaneous request after reset is granted to the dcache.

Structure
REQ-029 The state enum and the last_grant encoding SHALL reside in shared package arbiter_types.
REQ-030 The block SHALL be a single module with no sub-modules; the output steering SHALL be one combinational block keyed on state.

Verification
REQ-031 Icache-only: i_pmem_read=1, addr 0x0000_0060, adaptor resp after 4 cycles with rdata=0xA5 repeated -> pmem_read high from cycle 1, i_pmem_resp one pulse, d_pmem_resp stays 0.
REQ-032 Simultaneous after reset: i read 0x100 and d write 0x200 in the same cycle -> dcache served first (pmem_write=1, addr 0x200), then the icache (addr 0x100) after DONE+IDLE.
REQ-033 Round-robin under contention: both requesters held active through 4 transactions -> grant order D, I, D, I.
REQ-034 Late arrival: d read 0x300 raised while SERVE_I is active -> d not granted until icache resp, DONE and IDLE; pmem_address stays at the icache address until resp.
REQ-035 Reset mid-SERVE_D: rst pulsed 2 cycles into a write -> pmem_write drops to 0 asynchronously, the FSM is in IDLE, and the next tie is granted to the dcache.
